apb_rr_master: RTL and testbench
================================

APB_RR_MASTER -- requirements
Module: apb_rr_master

Interface
REQ-001 Parameter NREQ, 2, number of requesters sharing the APB master (legal 2..4).
REQ-002 Parameter TIMEOUT, 16, ACCESS-phase wait-cycle limit (used only with APB_TIMEOUT_EN).
REQ-003 Port PCLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port PRESETn  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  NREQ  per-requester transfer request.
REQ-006 Port req_write  input  NREQ  per-requester direction, 1 = write.
REQ-007 Port req_addr  input  NREQ*8  per-requester address, requester i in bits [8i+7:8i].
REQ-008 Port req_wdata  input  NREQ*32  per-requester write data, requester i in bits [32i+31:32i].
REQ-009 Port req_ready  output  NREQ  one-hot, single-cycle acceptance pulse.
REQ-010 Port rsp_valid  output  NREQ  one-hot, single-cycle completion pulse to the granted requester.
REQ-011 Port rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-012 Port rsp_err  output  1  completion error flag, qualified by rsp_valid.
REQ-013 Ports PSEL, PENABLE, PWRITE  output  1 each; PADDR  output  8; PWDATA  output  32: APB master signals.
REQ-014 Ports PRDATA  input  32; PREADY  input  1; PSLVERR  input  1: APB completer response.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP and ACCESS; PSEL/PENABLE SHALL be 0/0 in IDLE, 1/0 in SETUP and 1/1 in ACCESS.
REQ-016 In IDLE with any req_valid set, the block SHALL select one requester round-robin, starting the search at last_grant+1 modulo NREQ.
REQ-017 In that same IDLE cycle it SHALL pulse req_ready for the winner, register its write/addr/wdata and the grant index, update last_grant, and move to SETUP.
REQ-018 SETUP SHALL always advance to ACCESS after exactly one cycle.
REQ-019 In ACCESS with PREADY=0 the block SHALL stay in ACCESS with PADDR/PWRITE/PWDATA unchanged.
REQ-020 In ACCESS with PREADY=1 the block SHALL return to IDLE and register the completion for the next cycle: rsp_valid[grant]=1, rsp_err=PSLVERR, and rsp_rdata=PRDATA for error-free reads, otherwise 0.
REQ-021 Latency SHALL be as follows for a zero-wait completer: accept at cycle T, SETUP at T+1, ACCESS at T+2, rsp_valid at T+3; each PREADY=0 cycle adds one cycle.
REQ-022 At least one IDLE cycle SHALL separate consecutive transfers, with no back-to-back SETUP.
REQ-023 A requester SHALL hold its request stable until req_ready; dropping req_valid before acceptance SHALL cancel that request with no bus activity.
REQ-024 req_valid SHALL be ignored outside IDLE; req_ready SHALL be 0 outside IDLE.
REQ-025 PADDR/PWRITE/PWDATA SHALL hold their last values in IDLE.

Reset
REQ-026 While PRESETn=0 the block SHALL be in IDLE, all outputs 0, and last_grant=NREQ-1 so that requester 0 wins first.
REQ-027 Reset asserted mid-transfer SHALL abort immediately with no rsp_valid for the aborted transfer.

Configuration
REQ-028 With APB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles with PREADY=0 and clear on entry to SETUP.
REQ-029 With APB_TIMEOUT_EN defined, when that count reaches TIMEOUT the block SHALL go to IDLE and complete the transfer with rsp_err=1 and rsp_rdata=0.
REQ-030 Without APB_TIMEOUT_EN the block SHALL wait indefinitely for PREADY, and the counter logic SHALL be absent.

Structure
REQ-031 Package apb_pkg SHALL hold the state enum typedef (IDLE, SETUP, ACCESS) and the ADDR_W=8 and DATA_W=32 constants.
REQ-032 Round-robin selection SHALL be implemented in sub-module apb_rr_arb: request vector and last_grant in, one-hot grant and index out, combinational.

Verification
REQ-033 Single read, zero-wait: after reset, req_valid=01, req_write=0, addr 0x10, PRDATA=0xDEADBEEF -> PSEL at T+1, PENABLE at T+2, rsp_valid=01 with rdata 0xDEADBEEF at T+3.
REQ-034 Simultaneous requests: req_valid=11 held -> grants in order 0,1,0,1, each with a separate SETUP/ACCESS pair.
REQ-035 Wait states: write addr 0x44 wdata 0x12345678 with PREADY low for 3 ACCESS cycles -> PADDR/PWDATA stable throughout, rsp_valid 3 cycles later than zero-wait, rsp_rdata=0.
REQ-036 Error: PSLVERR=1 with PREADY=1 on a read -> rsp_err=1, rsp_rdata=0.
REQ-037 Reset in ACCESS: PRESETn low while PENABLE=1 -> PSEL=PENABLE=0 immediately, no rsp_valid; the next request from requester 0 wins first.
REQ-038 With APB_TIMEOUT_EN and TIMEOUT=16, PREADY held 0 -> return to IDLE after 16 ACCESS cycles, rsp_err=1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the round-robin APB master.
// The optional ACCESS-phase timeout is built in when APB_TIMEOUT_EN is defined.
package apb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Read data returned to a requester: only an error-free read carries PRDATA.
  function automatic logic [DATA_W-1:0] completion_rdata(
    input logic              write,
    input logic              err,
    input logic [DATA_W-1:0] prdata
  );
    return (write || err) ? '0 : prdata;
  endfunction

endpackage

// File: rtl/apb_rr_arb.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted requester and wraps, so every active requester is served in turn.
module apb_rr_arb #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_valid_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Pick the first active requester after last_grant_i, modulo NREQ.
  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    found         = 1'b0;
    cand          = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last_grant_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master shared by NREQ requesters through a round-robin arbiter.
// One transfer at a time: IDLE (accept) -> SETUP -> ACCESS -> IDLE, with the
// completion reported one cycle after PREADY. Defining APB_TIMEOUT_EN adds a
// wait-cycle limit that ends a stalled ACCESS phase with an error completion.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_W-1:0]      PADDR,
  output logic [DATA_W-1:0]      PWDATA,
  input  logic [DATA_W-1:0]      PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  localparam int IDX_W = $clog2(NREQ);

  apb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [NREQ-1:0]   ready_c;

  logic [NREQ-1:0]   arb_grant;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;

  // Per-requester views of the flat address/data buses.
  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  apb_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i         (req_valid),
    .last_grant_i  (last_grant_q),
    .grant_o       (arb_grant),
    .grant_idx_o   (arb_idx),
    .grant_valid_o (arb_valid)
  );

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Count of PREADY=0 cycles in the current ACCESS phase.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) wait_cnt_q <= '0;
    else          wait_cnt_q <= wait_cnt_d;
  end
`else
  // TIMEOUT only matters when the timeout option is built in.
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT > 0);
`endif

  // State register and transfer/completion registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NREQ - 1);
      grant_idx_q  <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_idx_q  <= grant_idx_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  // Next-state, acceptance and completion logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_idx_d  = grant_idx_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_valid_d  = '0;
    rsp_err_d    = 1'b0;
    rsp_rdata_d  = '0;
    ready_c      = '0;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          ready_c      = arb_grant;
          grant_idx_d  = arb_idx;
          last_grant_d = arb_idx;
          write_d      = req_write[arb_idx];
          addr_d       = addr_arr[arb_idx];
          wdata_d      = wdata_arr[arb_idx];
          state_d      = SETUP;
`ifdef APB_TIMEOUT_EN
          wait_cnt_d   = '0;
`endif
        end
      end

      SETUP: state_d = ACCESS;

      ACCESS: begin
        if (PREADY) begin
          state_d                  = IDLE;
          rsp_valid_d[grant_idx_q] = 1'b1;
          rsp_err_d                = PSLVERR;
          rsp_rdata_d              = completion_rdata(write_q, PSLVERR, PRDATA);
        end
`ifdef APB_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This stall cycle brings the count to TIMEOUT: give up with an error.
          wait_cnt_d               = wait_cnt_q + 1'b1;
          state_d                  = IDLE;
          rsp_valid_d[grant_idx_q] = 1'b1;
          rsp_err_d                = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // Acceptance is held low while reset is asserted, even with requests pending.
  assign req_ready = PRESETn ? ready_c : '0;

  assign PSEL      = (state_q != IDLE);
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = write_q;
  assign PADDR     = addr_q;
  assign PWDATA    = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master: requests are driven per scenario,
// expected completions are queued at acceptance and compared at rsp_valid.
module tb_apb_rr_master;

  localparam int NREQ       = 2;
  localparam int TB_TIMEOUT = 16;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_write;
  logic [NREQ*8-1:0] req_addr;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              PSEL, PENABLE, PWRITE;
  logic [7:0]        PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  apb_rr_master #(
    .NREQ    (NREQ),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   acc_log[$];
  int   acc_cyc_log[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_acc = 0;
  int n_rsp = 0;
  int acc_cyc = 0;
  int rsp_cyc = 0;

  // Completer behaviour for the current scenario.
  logic [31:0] cfg_prdata  = 32'h0;
  logic        cfg_pslverr = 1'b0;
  int          cfg_wait    = 0;
  int          wait_left   = 0;

  assign PRDATA  = cfg_prdata;
  assign PSLVERR = cfg_pslverr;

  // One clock: record acceptances just before the edge, then after the
  // following falling edge drive the completer and score any completion.
  task automatic clk_step();
    exp_t            e;
    int              idx;
    logic [NREQ-1:0] exp_v;
    #2;
    if (PRESETn === 1'b1 && req_ready !== '0) begin
      total++;
      if ($countones(req_ready) != 1) begin
        bad++;
        $display("FAIL ready_onehot: got %b required one-hot", req_ready);
      end
      idx = 0;
      for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) idx = i;
      e.idx = idx;
      e.err = cfg_pslverr;
`ifdef APB_TIMEOUT_EN
      if (cfg_wait >= TB_TIMEOUT) e.err = 1'b1;
`endif
      e.rdata = (req_write[idx] || e.err) ? 32'h0 : cfg_prdata;
      sb.push_back(e);
      acc_log.push_back(idx);
      acc_cyc_log.push_back(cyc);
      acc_cyc = cyc;
      n_acc++;
    end
    @(negedge PCLK);
    #1;
    cyc++;
    if (PSEL && !PENABLE) wait_left = cfg_wait;
    if (PSEL && PENABLE) begin
      PREADY = (wait_left == 0);
      if (wait_left > 0) wait_left--;
    end else begin
      PREADY = 1'b0;
    end
    if (rsp_valid !== '0) begin
      n_rsp++;
      rsp_cyc = cyc;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got rsp_valid=%b required none", rsp_valid);
      end else begin
        e = sb.pop_front();
        exp_v = NREQ'(1) << e.idx;
        if (rsp_valid !== exp_v || rsp_err !== e.err || rsp_rdata !== e.rdata) begin
          bad++;
          $display("FAIL rsp_data: got valid=%b err=%b rdata=%h required valid=%b err=%b rdata=%h",
                   rsp_valid, rsp_err, rsp_rdata, exp_v, e.err, e.rdata);
        end
      end
    end
  endtask

  task automatic wait_acc(input int target, input string what);
    int budget;
    budget = 60;
    while (n_acc < target && budget > 0) begin
      clk_step();
      budget--;
    end
    total++;
    if (n_acc < target) begin
      bad++;
      $display("FAIL %s_accept_wait: got %0d acceptances required %0d", what, n_acc, target);
    end
  endtask

  task automatic wait_rsp(input int target, input string what);
    int budget;
    budget = 60;
    while (n_rsp < target && budget > 0) begin
      clk_step();
      budget--;
    end
    total++;
    if (n_rsp < target) begin
      bad++;
      $display("FAIL %s_rsp_wait: got %0d completions required %0d", what, n_rsp, target);
    end
  endtask

  task automatic test_reset();
    PRESETn   = 1'b0;
    req_valid = '1;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    PREADY    = 1'b0;
    repeat (3) @(negedge PCLK);
    #1;
    total++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl: got psel/penable/pwrite=%b required 000", {PSEL, PENABLE, PWRITE});
    end
    total++;
    if (PADDR !== 8'h0 || PWDATA !== 32'h0) begin
      bad++;
      $display("FAIL reset_bus: got paddr=%h pwdata=%h required 0", PADDR, PWDATA);
    end
    total++;
    if (req_ready !== '0) begin
      bad++;
      $display("FAIL reset_ready: got %b required 0", req_ready);
    end
    total++;
    if (rsp_valid !== '0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h required 0", rsp_valid, rsp_err, rsp_rdata);
    end
    req_valid = '0;
    PRESETn   = 1'b1;
    repeat (2) clk_step();
    total++;
    if (PSEL !== 1'b0 || n_acc != 0) begin
      bad++;
      $display("FAIL reset_idle: got psel=%b acceptances=%0d required 0/0", PSEL, n_acc);
    end
  endtask

  task automatic test_simultaneous();
    int base_acc, base_rsp, setup_cnt, budget;
    logic [7:0] exp_addr;
    cfg_prdata  = 32'h0BADF00D;
    cfg_pslverr = 1'b0;
    cfg_wait    = 0;
    base_acc    = n_acc;
    base_rsp    = n_rsp;
    setup_cnt   = 0;
    req_write   = '0;
    req_addr    = {8'h31, 8'h20};
    req_valid   = 2'b11;
    budget      = 60;
    while ((n_acc < base_acc + 4 || n_rsp < base_rsp + 4) && budget > 0) begin
      clk_step();
      budget--;
      if (n_acc >= base_acc + 4) req_valid = '0;
      if (PSEL && !PENABLE) begin
        setup_cnt++;
        exp_addr = (acc_log[acc_log.size()-1] == 0) ? 8'h20 : 8'h31;
        total++;
        if (PADDR !== exp_addr) begin
          bad++;
          $display("FAIL rr_paddr: got %h required %h", PADDR, exp_addr);
        end
      end
    end
    req_valid = '0;
    total++;
    if (n_acc != base_acc + 4 || n_rsp != base_rsp + 4) begin
      bad++;
      $display("FAIL rr_count: got acc=%0d rsp=%0d required %0d/%0d", n_acc - base_acc, n_rsp - base_rsp, 4, 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (acc_log[base_acc + i] != (i % 2)) begin
          bad++;
          $display("FAIL rr_order: grant %0d got requester %0d required %0d", i, acc_log[base_acc + i], i % 2);
        end
      end
      for (int i = 1; i < 4; i++) begin
        total++;
        if (acc_cyc_log[base_acc + i] - acc_cyc_log[base_acc + i - 1] != 3) begin
          bad++;
          $display("FAIL rr_spacing: got %0d cycles required 3",
                   acc_cyc_log[base_acc + i] - acc_cyc_log[base_acc + i - 1]);
        end
      end
    end
    total++;
    if (setup_cnt != 4) begin
      bad++;
      $display("FAIL rr_setups: got %0d required 4", setup_cnt);
    end
  endtask

  task automatic test_single_read();
    int base_acc, base_rsp;
    cfg_prdata  = 32'hDEADBEEF;
    cfg_pslverr = 1'b0;
    cfg_wait    = 0;
    base_acc    = n_acc;
    base_rsp    = n_rsp;
    req_write   = '0;
    req_addr    = {8'h00, 8'h10};
    req_valid   = 2'b01;
    wait_acc(base_acc + 1, "read");
    req_valid = '0;
    total++;
    if (acc_log[acc_log.size()-1] != 0) begin
      bad++;
      $display("FAIL read_grant: got %0d required 0", acc_log[acc_log.size()-1]);
    end
    total++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 8'h10 || PWRITE !== 1'b0) begin
      bad++;
      $display("FAIL read_setup: got psel=%b penable=%b paddr=%h pwrite=%b required 1 0 10 0",
               PSEL, PENABLE, PADDR, PWRITE);
    end
    clk_step();
    total++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
      bad++;
      $display("FAIL read_access: got psel=%b penable=%b required 1 1", PSEL, PENABLE);
    end
    clk_step();
    total++;
    if (n_rsp != base_rsp + 1 || rsp_cyc - acc_cyc != 3 || PSEL !== 1'b0) begin
      bad++;
      $display("FAIL read_latency: got rsp=%0d latency=%0d psel=%b required 1 3 0",
               n_rsp - base_rsp, rsp_cyc - acc_cyc, PSEL);
    end
  endtask

  task automatic test_wait_states();
    int base_acc, base_rsp, access_cnt, budget;
    cfg_prdata  = 32'hFFFFFFFF;
    cfg_pslverr = 1'b0;
    cfg_wait    = 3;
    base_acc    = n_acc;
    base_rsp    = n_rsp;
    access_cnt  = 0;
    req_write   = 2'b01;
    req_addr    = {8'h00, 8'h44};
    req_wdata   = {32'h0, 32'h12345678};
    req_valid   = 2'b01;
    wait_acc(base_acc + 1, "wait");
    req_valid = '0;
    budget    = 30;
    while (n_rsp < base_rsp + 1 && budget > 0) begin
      if (PSEL && PENABLE) begin
        access_cnt++;
        total++;
        if (PADDR !== 8'h44 || PWDATA !== 32'h12345678 || PWRITE !== 1'b1) begin
          bad++;
          $display("FAIL wait_hold: got paddr=%h pwdata=%h pwrite=%b required 44 12345678 1",
                   PADDR, PWDATA, PWRITE);
        end
      end
      clk_step();
      budget--;
    end
    total++;
    if (access_cnt != 4 || rsp_cyc - acc_cyc != 6) begin
      bad++;
      $display("FAIL wait_latency: got access=%0d latency=%0d required 4 6", access_cnt, rsp_cyc - acc_cyc);
    end
    clk_step();
    total++;
    if (PSEL !== 1'b0 || PADDR !== 8'h44 || PWDATA !== 32'h12345678) begin
      bad++;
      $display("FAIL idle_hold: got psel=%b paddr=%h pwdata=%h required 0 44 12345678", PSEL, PADDR, PWDATA);
    end
    req_write = '0;
  endtask

  task automatic test_error();
    int base_acc, base_rsp;
    cfg_prdata  = 32'hCAFEBABE;
    cfg_pslverr = 1'b1;
    cfg_wait    = 0;
    base_acc    = n_acc;
    base_rsp    = n_rsp;
    req_write   = '0;
    req_addr    = {8'h7C, 8'h00};
    req_valid   = 2'b10;
    wait_acc(base_acc + 1, "error");
    req_valid = '0;
    total++;
    if (acc_log[acc_log.size()-1] != 1) begin
      bad++;
      $display("FAIL error_grant: got %0d required 1", acc_log[acc_log.size()-1]);
    end
    wait_rsp(base_rsp + 1, "error");
    clk_step();
    total++;
    if (rsp_valid !== '0) begin
      bad++;
      $display("FAIL error_pulse: got rsp_valid=%b required 00", rsp_valid);
    end
    cfg_pslverr = 1'b0;
  endtask

  task automatic test_busy_ignore();
    int base_acc, base_rsp;
    logic psel_seen;
    cfg_prdata = 32'h55AA55AA;
    cfg_wait   = 2;
    base_acc   = n_acc;
    base_rsp   = n_rsp;
    req_write  = '0;
    req_addr   = {8'h66, 8'h50};
    req_valid  = 2'b01;
    wait_acc(base_acc + 1, "busy");
    req_valid = 2'b10;
    #1;
    total++;
    if (req_ready !== '0) begin
      bad++;
      $display("FAIL busy_ready_setup: got %b required 00", req_ready);
    end
    clk_step();
    #1;
    total++;
    if (req_ready !== '0) begin
      bad++;
      $display("FAIL busy_ready_access: got %b required 00", req_ready);
    end
    req_valid = '0;
    wait_rsp(base_rsp + 1, "busy");
    psel_seen = 1'b0;
    repeat (4) begin
      clk_step();
      if (PSEL) psel_seen = 1'b1;
    end
    total++;
    if (n_acc != base_acc + 1 || psel_seen !== 1'b0) begin
      bad++;
      $display("FAIL cancel: got acceptances=%0d psel_seen=%b required 1 0", n_acc - base_acc, psel_seen);
    end
  endtask

  task automatic test_reset_in_access();
    int base_acc, base_rsp;
    cfg_prdata = 32'h13579BDF;
    cfg_wait   = 5;
    base_acc   = n_acc;
    req_write  = '0;
    req_addr   = {8'h22, 8'h11};
    req_valid  = 2'b01;
    wait_acc(base_acc + 1, "abort");
    req_valid = '0;
    clk_step();
    total++;
    if (PENABLE !== 1'b1) begin
      bad++;
      $display("FAIL abort_access: got penable=%b required 1", PENABLE);
    end
    PRESETn = 1'b0;
    #1;
    total++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== '0) begin
      bad++;
      $display("FAIL abort_now: got psel=%b penable=%b rsp_valid=%b required 0 0 00", PSEL, PENABLE, rsp_valid);
    end
    sb.delete();
    base_rsp = n_rsp;
    repeat (2) clk_step();
    PRESETn = 1'b1;
    repeat (3) clk_step();
    total++;
    if (n_rsp != base_rsp) begin
      bad++;
      $display("FAIL abort_rsp: got %0d completions required 0", n_rsp - base_rsp);
    end
    cfg_wait  = 0;
    base_acc  = n_acc;
    req_valid = 2'b11;
    wait_acc(base_acc + 1, "post_reset");
    req_valid = '0;
    total++;
    if (acc_log[acc_log.size()-1] != 0) begin
      bad++;
      $display("FAIL post_reset_grant: got %0d required 0", acc_log[acc_log.size()-1]);
    end
    wait_rsp(base_rsp + 1, "post_reset");
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    int base_acc, base_rsp, access_cnt, budget;
    cfg_prdata = 32'hA5A5A5A5;
    cfg_wait   = 1000;
    base_acc   = n_acc;
    base_rsp   = n_rsp;
    access_cnt = 0;
    req_write  = '0;
    req_addr   = {8'h0F, 8'h0E};
    req_valid  = 2'b10;
    wait_acc(base_acc + 1, "timeout");
    req_valid = '0;
    budget    = 60;
    while (n_rsp < base_rsp + 1 && budget > 0) begin
      if (PSEL && PENABLE) access_cnt++;
      clk_step();
      budget--;
    end
    total++;
    if (access_cnt != TB_TIMEOUT || n_rsp != base_rsp + 1) begin
      bad++;
      $display("FAIL timeout_len: got access=%0d rsp=%0d required %0d 1", access_cnt, n_rsp - base_rsp, TB_TIMEOUT);
    end
    cfg_wait = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_simultaneous();
    test_single_read();
    test_wait_states();
    test_error();
    test_busy_ignore();
    test_reset_in_access();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) clk_step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
